// File: rtl/fetch_unit.sv
// Instruction fetch: PC + single-outstanding imem req/ack, one instr per 2 cycles with same-cycle ack.
// Backpressure: stall holds the presented instruction; redirects flush HOLD or retarget a pending request.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_base_pc,
  input  logic [31:0]      branch_imm,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  output logic [6:0]       op_code,
  output logic             misaligned,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic               misaligned_q, misaligned_d;
  logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;
  logic               pend_q, pend_d;
  logic [31:0]        pend_pc_q, pend_pc_d;

  logic [31:0]        tgt;
  logic [31:0]        tgt_al;

  assign tgt    = branch_base_pc + branch_imm;
  assign tgt_al = {tgt[31:2], 2'b00};

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    misaligned_d  = misaligned_q;
    fetch_count_d = fetch_count_q;
    pend_d        = pend_q;
    pend_pc_d     = pend_pc_q;

    if (branch_taken && (tgt[1:0] != 2'b00)) begin
      misaligned_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (branch_taken) begin
          pc_d = tgt_al;
        end
        state_d = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          if (!pend_q && !branch_taken) begin
            instr_d       = imem_rdata;
            instr_pc_d    = pc_q;
            pc_d          = pc_q + 32'd4;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end else begin
            // Wrong-path data: drop it and reissue at the newest target.
            pc_d   = branch_taken ? tgt_al : pend_pc_q;
            pend_d = 1'b0;
          end
        end else if (branch_taken) begin
          pend_d    = 1'b1;
          pend_pc_d = tgt_al;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          instr_valid_d = 1'b0;
          pc_d          = tgt_al;
          state_d       = REQ;
        end else if (!stall) begin
          fetch_count_d = fetch_count_q + CNT_W'(1);
          instr_valid_d = 1'b0;
          state_d       = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      fetch_count_q <= '0;
      pend_q        <= 1'b0;
      pend_pc_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      misaligned_q  <= misaligned_d;
      fetch_count_q <= fetch_count_d;
      pend_q        <= pend_d;
      pend_pc_q     <= pend_pc_d;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign op_code     = instr_q[6:0];
  assign misaligned  = misaligned_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the immediate generator and decoder.
- Holds the program counter and issues single-outstanding requests to instruction memory over a req/ack handshake.
- Presents the fetched word, its PC and its opcode field to decode.
- Takes branch redirects computed as branch PC + sign-extended immediate, and flushes or discards any wrong-path fetch.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- CNT_W, 16: width of the delivered-instruction counter.

Ports:
- clk  in  1: rising-edge clock.
- rst_n  in  1: asynchronous, active-low reset.
- stall  in  1: decode not ready; hold the presented instruction.
- branch_taken  in  1: one-cycle redirect strobe.
- branch_base_pc  in  32: PC of the branching instruction.
- branch_imm  in  32: sign-extended immediate, already carrying bit0 = 0.
- imem_req  out  1: fetch request.
- imem_addr  out  32: fetch address; stable while imem_req = 1.
- imem_ack  in  1: memory response valid; may arrive in the same cycle as imem_req or later.
- imem_rdata  in  32: fetched word; valid with imem_ack.
- instr_valid  out  1: instr and instr_pc are valid.
- instr  out  32: fetched instruction.
- instr_pc  out  32: address of instr.
- op_code  out  7: instr[6:0].
- misaligned  out  1: sticky flag; a redirect target had target[1:0] != 0.
- fetch_count  out  CNT_W: count of instructions accepted by decode.

Behaviour:
- Reset (asynchronous, immediate):
  - State = IDLE, pc = RESET_PC.
  - Outputs: imem_req = 0, instr_valid = 0, instr = 0, instr_pc = 0, misaligned = 0, fetch_count = 0.
  - Redirect-pending flag cleared.
  - Reset mid-request drops imem_req at once; the late ack is ignored because state is IDLE.
- FSM states and transitions:
  - IDLE: imem_req = 0. Next cycle goes to REQ.
  - REQ: imem_req = 1, imem_addr = pc. On imem_ack:
    - If no redirect is pending and branch_taken = 0: instr <= imem_rdata, instr_pc <= pc, pc <= pc + 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0), instr_valid <= 1, go to HOLD.
    - Otherwise: discard the data, pc <= redirect target, clear pending, stay in REQ. The next cycle presents a new request at the target.
  - HOLD: instr_valid = 1, imem_req = 0.
    - An instruction is accepted when instr_valid && !stall. On acceptance: fetch_count += 1 (wraps), instr_valid <= 0, go to REQ.
    - stall = 1 holds instr, instr_pc and instr_valid unchanged.
- Throughput: one instruction every 2 cycles with a same-cycle-ack memory. Each extra memory wait cycle adds 1.
- Redirect:
  - Target = branch_base_pc + branch_imm, 32-bit, carry discarded.
  - Loaded PC = {target[31:2], 2'b00}.
  - If target[1:0] != 0, set misaligned (sticky until reset).
  - Redirect in IDLE: pc <= target; the transition to REQ is unchanged.
  - Redirect in REQ without ack: latch target, set pending; imem_req and imem_addr stay stable (no request abandonment). A second redirect while pending overwrites the latched target (last wins).
  - Redirect in REQ with ack in the same cycle: discard the data and use the new target directly.
  - Redirect in HOLD: flush. instr_valid <= 0, pc <= target, go to REQ. The flushed instruction is not counted, even if stall = 0 in the same cycle (branch beats acceptance).
- Outputs are registered, except op_code = instr[6:0], imem_req and imem_addr, which are decoded from state and pc.

Test Plan:
- Reset and sequential fetch: RESET_PC = 0, memory acks same cycle with rdata = addr ^ 32'hA5A5_0000, stall = 0.
  - Required: imem_addr sequence 0, 4, 8, 12.
  - Required: instr_valid pulses every 2nd cycle with matching instr_pc.
  - Required: fetch_count = 4 after the 4th acceptance.
- Wait-state memory plus stall:
  - Ack delayed 3 cycles: imem_addr stays stable until ack.
  - Then stall held 5 cycles: instr, instr_pc and instr_valid stay constant; fetch_count unchanged until stall drops.
- Redirect in HOLD: instr_pc = 0x100 held, branch_taken with base 0x100, imm 0xFFFF_FFF0.
  - Required: instr_valid drops, next imem_addr = 0x0F0, fetch_count not incremented.
- Redirect while request pending: request at 0x20 outstanding, branch_taken (base 0x40, imm 0x8), then ack 2 cycles later.
  - Required: data from 0x20 never appears on instr.
  - Required: next imem_addr = 0x48.
- Misaligned target and wrap: base 0x10, imm 0x2.
  - Required: misaligned = 1 (stays set), fetch at 0x10.
  - Separately, pc = 0xFFFF_FFFC fetched: next imem_addr = 0x0.
- Async reset mid-request: assert rst_n = 0 with imem_req = 1.
  - Required: imem_req = 0 immediately.
  - Required: after release, first request at RESET_PC.
